// File: rtl/alu_op_issuer_if.sv
// Bundle of the request, ALU-drive and response signals of alu_op_issuer.
// slave = the issuer side, master = the requester/ALU/consumer environment.
interface alu_op_issuer_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [4:0]  req_code;
  logic        req_coe;

  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [4:0]  alu_code;
  logic        alu_coe;
  logic [15:0] alu_c;
  logic        alu_vout;
  logic        alu_cout;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_c;
  logic        rsp_vout;
  logic        rsp_cout;
  logic [4:0]  rsp_code;

  modport slave (
    input  req_valid, req_a, req_b, req_code, req_coe,
    output req_ready,
    output alu_a, alu_b, alu_code, alu_coe,
    input  alu_c, alu_vout, alu_cout,
    output rsp_valid, rsp_c, rsp_vout, rsp_cout, rsp_code,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_a, req_b, req_code, req_coe,
    input  req_ready,
    input  alu_a, alu_b, alu_code, alu_coe,
    output alu_c, alu_vout, alu_cout,
    input  rsp_valid, rsp_c, rsp_vout, rsp_cout, rsp_code,
    output rsp_ready
  );
endinterface

// File: rtl/alu_op_issuer.sv
// Issues one operation at a time to a combinational ALU, waits SETTLE_CYCLES, returns the result.
// Optional macro ALU_OVF_CNT_EN adds a saturating 8-bit overflow counter output ovf_cnt.
module alu_op_issuer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  alu_op_issuer_if.slave  bus,
  output logic            busy
`ifdef ALU_OVF_CNT_EN
  ,
  output logic [7:0]      ovf_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] LP_CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic        w_accept;
  logic        w_capture;
  logic [3:0]  r_cnt;

  logic [15:0] r_alu_a;
  logic [15:0] r_alu_b;
  logic [4:0]  r_alu_code;
  logic        r_alu_coe;

  logic [15:0] r_rsp_c;
  logic        r_rsp_vout;
  logic        r_rsp_cout;
  logic [4:0]  r_rsp_code;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_accept     = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (r_cnt == 4'd0) begin
          w_capture    = 1'b1;
          w_next_state = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      if (w_accept)
        r_cnt <= LP_CNT_LOAD;
      else if (r_state == ISSUE && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
    end
  end

  // Operand registers only load on accept, so req_* never reaches the ALU combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a    <= 16'd0;
      r_alu_b    <= 16'd0;
      r_alu_code <= 5'd0;
      r_alu_coe  <= 1'b1;
    end else if (w_accept) begin
      r_alu_a    <= bus.req_a;
      r_alu_b    <= bus.req_b;
      r_alu_code <= bus.req_code;
      r_alu_coe  <= bus.req_coe;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_c    <= 16'd0;
      r_rsp_vout <= 1'b0;
      r_rsp_cout <= 1'b0;
      r_rsp_code <= 5'd0;
    end else if (w_capture) begin
      r_rsp_c    <= bus.alu_c;
      r_rsp_vout <= bus.alu_vout;
      r_rsp_cout <= bus.alu_cout;
      r_rsp_code <= r_alu_code;
    end
  end

`ifdef ALU_OVF_CNT_EN
  logic [7:0] r_ovf_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_ovf_cnt <= 8'd0;
    else if (w_capture && bus.alu_vout && r_ovf_cnt != 8'hFF)
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign busy          = (r_state != IDLE);

  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_code  = r_alu_code;
  assign bus.alu_coe   = r_alu_coe;

  assign bus.rsp_c     = r_rsp_c;
  assign bus.rsp_vout  = r_rsp_vout;
  assign bus.rsp_cout  = r_rsp_cout;
  assign bus.rsp_code  = r_rsp_code;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer: one instance with SETTLE_CYCLES=1 and a small ALU model,
// one with SETTLE_CYCLES=3 whose ALU result is driven step by step.
module tb_alu_op_issuer;

  logic clk = 1'b0;
  logic rst;
  logic busy1, busy3;
`ifdef ALU_OVF_CNT_EN
  logic [7:0] ovf_cnt1, ovf_cnt3;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_issuer_if if1 ();
  alu_op_issuer_if if3 ();

  alu_op_issuer #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .busy(busy1)
`ifdef ALU_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt1)
`endif
  );

  alu_op_issuer #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .bus(if3), .busy(busy3)
`ifdef ALU_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt3)
`endif
  );

  always #5 clk = ~clk;

  // ALU model for dut1: 00000 add, 10011 arithmetic shift right, anything else xor.
  logic [16:0] sum17;
  always_comb begin
    sum17        = {1'b0, if1.alu_a} + {1'b0, if1.alu_b};
    if1.alu_c    = if1.alu_a ^ if1.alu_b;
    if1.alu_vout = 1'b0;
    if1.alu_cout = 1'b0;
    if (if1.alu_code == 5'b00000) begin
      if1.alu_c    = sum17[15:0];
      if1.alu_vout = (if1.alu_a[15] == if1.alu_b[15]) && (sum17[15] != if1.alu_a[15]);
      if1.alu_cout = ~if1.alu_coe & sum17[16];
    end else if (if1.alu_code == 5'b10011) begin
      if1.alu_c = $signed(if1.alu_a) >>> if1.alu_b[3:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic [4:0] code, input logic coe);
    if1.req_valid = v;
    if1.req_a     = a;
    if1.req_b     = b;
    if1.req_code  = code;
    if1.req_coe   = coe;
  endtask

  initial begin
    rst = 1'b1;
    drive1(1'b0, 16'h0, 16'h0, 5'd0, 1'b1);
    if1.rsp_ready = 1'b0;
    if3.req_valid = 1'b0;
    if3.req_a     = 16'h0;
    if3.req_b     = 16'h0;
    if3.req_code  = 5'd0;
    if3.req_coe   = 1'b1;
    if3.rsp_ready = 1'b0;
    if3.alu_c     = 16'h0BAD;
    if3.alu_vout  = 1'b0;
    if3.alu_cout  = 1'b0;

    // Reset values
    tick(); tick();
    check("rst_busy",      busy1,         0);
    check("rst_rsp_valid", if1.rsp_valid, 0);
    check("rst_alu_a",     if1.alu_a,     0);
    check("rst_alu_coe",   if1.alu_coe,   1);
    check("rst_rsp_c",     if1.rsp_c,     0);
    check("rst_rsp_code",  if1.rsp_code,  0);
    rst = 1'b0;
    check("rst_req_ready", if1.req_ready, 1);
    tick();
    check("post_rst_req_ready", if1.req_ready, 1);

    // Signed overflow add, SETTLE_CYCLES=1
    drive1(1'b1, 16'h7FFF, 16'h0001, 5'b00000, 1'b0);
    tick();
    if1.req_valid = 1'b0;
    check("add_busy",       busy1,         1);
    check("add_req_ready",  if1.req_ready, 0);
    check("add_not_valid",  if1.rsp_valid, 0);
    check("add_alu_a",      if1.alu_a,     16'h7FFF);
    tick();
    check("add_rsp_valid",  if1.rsp_valid, 1);
    check("add_rsp_c",      if1.rsp_c,     16'h8000);
    check("add_rsp_vout",   if1.rsp_vout,  1);
    check("add_rsp_cout",   if1.rsp_cout,  0);
    check("add_rsp_code",   if1.rsp_code,  5'b00000);
    if1.rsp_ready = 1'b1;
    tick();
    check("add_done_valid", if1.rsp_valid, 0);
    check("add_done_busy",  busy1,         0);
    check("add_rsp_kept",   if1.rsp_c,     16'h8000);

    // Arithmetic shift, rsp_ready held high: one-cycle rsp_valid
    drive1(1'b1, 16'h8000, 16'h0004, 5'b10011, 1'b0);
    tick();
    if1.req_valid = 1'b0;
    tick();
    check("asr_rsp_valid",  if1.rsp_valid, 1);
    check("asr_rsp_c",      if1.rsp_c,     16'hF800);
    check("asr_rsp_vout",   if1.rsp_vout,  0);
    check("asr_rsp_cout",   if1.rsp_cout,  0);
    check("asr_rsp_code",   if1.rsp_code,  5'b10011);
    tick();
    check("asr_valid_drop", if1.rsp_valid, 0);

    // Backpressure in RESP with new request pending
    if1.rsp_ready = 1'b0;
    drive1(1'b1, 16'h1234, 16'h1111, 5'b00000, 1'b1);
    tick();
    drive1(1'b1, 16'hAAAA, 16'h5555, 5'b00001, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", if1.rsp_valid, 1);
      check("bp_rsp_c",     if1.rsp_c,     16'h2345);
      check("bp_req_ready", if1.req_ready, 0);
      check("bp_alu_a",     if1.alu_a,     16'h1234);
      check("bp_alu_code",  if1.alu_code,  5'b00000);
      tick();
    end
    if1.rsp_ready = 1'b1;
    tick();
    check("bp_release_valid", if1.rsp_valid, 0);
    check("bp_release_ready", if1.req_ready, 1);
    tick();
    if1.req_valid = 1'b0;
    check("bp_new_alu_a",    if1.alu_a,    16'hAAAA);
    check("bp_new_alu_code", if1.alu_code, 5'b00001);
    tick();
    check("xor_rsp_c",       if1.rsp_c,    16'hFFFF);
    check("xor_rsp_code",    if1.rsp_code, 5'b00001);
    tick();
    check("xor_idle",        busy1,        0);

    // SETTLE_CYCLES=3: result sampled at the third edge after accept
    if3.req_valid = 1'b1;
    if3.req_a     = 16'h0042;
    if3.req_b     = 16'h0007;
    if3.req_code  = 5'b00101;
    if3.req_coe   = 1'b0;
    tick();
    if3.req_valid = 1'b0;
    if3.alu_c = 16'h1111;
    tick();
    check("s3_edge1_valid", if3.rsp_valid, 0);
    check("s3_edge1_busy",  busy3,         1);
    if3.alu_c = 16'h2222;
    tick();
    check("s3_edge2_valid", if3.rsp_valid, 0);
    if3.alu_c = 16'h3333;
    tick();
    check("s3_edge3_valid", if3.rsp_valid, 1);
    check("s3_rsp_c",       if3.rsp_c,     16'h3333);
    check("s3_rsp_code",    if3.rsp_code,  5'b00101);
    if3.alu_c = 16'h4444;
    tick();
    check("s3_rsp_hold",    if3.rsp_c,     16'h3333);
    if3.rsp_ready = 1'b1;
    tick();
    check("s3_done_valid",  if3.rsp_valid, 0);

    // Reset while in ISSUE discards the operation
    if3.req_valid = 1'b1;
    tick();
    if3.req_valid = 1'b0;
    tick();
    check("rstiss_busy_before", busy3, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstiss_busy",      busy3,         0);
    check("rstiss_rsp_valid", if3.rsp_valid, 0);
    check("rstiss_alu_a",     if3.alu_a,     0);
    check("rstiss_alu_coe",   if3.alu_coe,   1);
    check("rstiss_rsp_c",     if3.rsp_c,     0);
    check("rstiss_req_ready", if3.req_ready, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rstiss_no_rsp", if3.rsp_valid, 0);
    end

`ifdef ALU_OVF_CNT_EN
    // Overflow counter saturation
    check("ovf_after_rst", ovf_cnt1, 0);
    if1.rsp_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive1(1'b1, 16'h7FFF, 16'h0001, 5'b00000, 1'b0);
      tick();
      if1.req_valid = 1'b0;
      tick();
      tick();
    end
    check("ovf_saturated", ovf_cnt1, 8'd255);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ovf_reset", ovf_cnt1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_issuer.md
ALU_OP_ISSUER -- requirements
Module: alu_op_issuer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, the number of cycles operands are held on the ALU bus before the result is sampled; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, the requester has an operation pending.
REQ-005 SHALL have port req_ready, output, 1, the issuer can accept an operation.
REQ-006 SHALL have ports req_a and req_b, input, 16 each, signed operands.
REQ-007 SHALL have ports req_code (input, 5, ALU op code) and req_coe (input, 1, active-low carry-out enable).
REQ-008 SHALL have ports alu_a, alu_b (output, 16 each), alu_code (output, 5) and alu_coe (output, 1), all driving the combinational ALU.
REQ-009 SHALL have ports alu_c (input, 16), alu_vout (input, 1) and alu_cout (input, 1), the ALU result.
REQ-010 SHALL have port rsp_valid, output, 1, a result is available.
REQ-011 SHALL have port rsp_ready, input, 1, the consumer accepts the result.
REQ-012 SHALL have ports rsp_c (output, 16), rsp_vout (output, 1), rsp_cout (output, 1) and rsp_code (output, 5, echo of the issued code).
REQ-013 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-014 SHALL implement an FSM with states IDLE, ISSUE and RESP.
REQ-015 In IDLE: req_ready=1; req_valid=1 at a rising edge registers req_a/b/code/coe onto alu_a/b/code/coe; next state ISSUE; the settle counter loads SETTLE_CYCLES-1.
REQ-016 In ISSUE: req_ready=0; alu_* are held stable; the counter decrements each cycle.
REQ-017 At the ISSUE edge where the counter is 0: alu_c/vout/cout are registered into rsp_c/vout/cout and alu_code into rsp_code; next state RESP.
REQ-018 Latency: rsp_valid SHALL rise exactly SETTLE_CYCLES rising edges after the accepting edge.
REQ-019 In RESP: rsp_valid=1 and rsp_* stable until the edge with rsp_ready=1; then IDLE with rsp_valid=0.
REQ-020 Only one operation in flight; req_ready SHALL be 0 in ISSUE and RESP; throughput is one operation per SETTLE_CYCLES+2 cycles when rsp_ready is held high.
REQ-021 alu_* SHALL hold the last issued operands in IDLE and RESP, with no combinational path from req_* to alu_*.
REQ-022 rsp_* SHALL retain the last result after the handshake until overwritten.
REQ-023 req_* SHALL be ignored outside IDLE; changes there SHALL NOT affect alu_*.

Reset
REQ-024 With rst=1 at a rising edge: state=IDLE, counter=0, rsp_valid=0, busy=0, alu_a/b=0, alu_code=0, alu_coe=1, rsp_c=0, rsp_vout=0, rsp_cout=0, rsp_code=0.
REQ-025 Reset in ISSUE or RESP SHALL discard the in-flight operation, and no response SHALL be produced.
REQ-026 req_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-027 With ALU_OVF_CNT_EN defined, the block SHALL add output ovf_cnt (8 bits, reset 0) that increments at each REQ-017 capture with alu_vout=1, saturating at 255.
REQ-028 Without ALU_OVF_CNT_EN, the port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 SETTLE_CYCLES=1, a=0x7FFF, b=0x0001, code=00000, coe=0, ALU model C=0x8000, vout=1 -> rsp_valid one edge after accept; rsp_c=0x8000, rsp_vout=1, rsp_code=00000.
REQ-030 code=10011, a=0x8000, b=0x0004 -> rsp_c=0xF800, rsp_vout=0, rsp_cout=0; rsp_valid high exactly one cycle with rsp_ready=1.
REQ-031 rsp_ready=0 for 5 cycles in RESP, while req_valid=1 with new operands -> rsp_* unchanged, req_ready=0, alu_* unchanged; accepted after rsp_ready=1.
REQ-032 SETTLE_CYCLES=3, ALU model output changing each cycle -> rsp_c equals the model value present at the third edge after accept.
REQ-033 rst=1 during ISSUE -> next cycle outputs at reset values and busy=0; no rsp_valid pulse follows.
REQ-034 ALU_OVF_CNT_EN defined, 300 operations with vout=1 -> ovf_cnt=255; after reset ovf_cnt=0.
